// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA raster timing path.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_pkg;

    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;

    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;

    localparam bit SYNC_ACT_LOW  = 1'b0;
    localparam bit SYNC_ACT_HIGH = 1'b1;

    function automatic int unsigned seg_total(
        input int unsigned sync,
        input int unsigned bp,
        input int unsigned active,
        input int unsigned fp
    );
        return sync + bp + active + fp;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the raster generator to its consumers.
// frame_cnt is only present when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned FRAME_W = 8
);
    logic               HS;
    logic               VS;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               disp_en;
    logic               pix_en;
    logic               line_start;
    logic               frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt;

    modport master (output HS, VS, col, row, disp_en, pix_en, line_start, frame_start, frame_cnt);
    modport slave  (input  HS, VS, col, row, disp_en, pix_en, line_start, frame_start, frame_cnt);
`else
    modport master (output HS, VS, col, row, disp_en, pix_en, line_start, frame_start);
    modport slave  (input  HS, VS, col, row, disp_en, pix_en, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync/active decode of the position
// this edge will produce, so the parent can register outputs without latency.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned SYNC    = 96,
    parameter int unsigned BP      = 48,
    parameter int unsigned ACTIVE  = 640,
    parameter int unsigned FP      = 16,
    parameter int unsigned COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv,
    output logic               wrap,
    output logic               in_sync,
    output logic               in_active,
    output logic [COORD_W-1:0] coord
);

    localparam int unsigned TOTAL     = seg_total(SYNC, BP, ACTIVE, FP);
    localparam int unsigned CW        = cnt_width(TOTAL);
    localparam int unsigned ACT_START = SYNC + BP;
    localparam int unsigned ACT_END   = SYNC + BP + ACTIVE;
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);

    logic [CW-1:0] pos_reg;
    logic [CW-1:0] pos_next;
    logic [31:0]   pos_wide;

    assign wrap = (pos_reg == LAST);

    always_comb begin
        pos_next = pos_reg;
        if (adv) begin
            pos_next = wrap ? '0 : pos_reg + CW'(1);
        end
    end

    assign pos_wide  = 32'(pos_next);
    assign in_sync   = (pos_wide < SYNC);
    assign in_active = (pos_wide >= ACT_START) && (pos_wide < ACT_END);
    assign coord     = in_active ? COORD_W'(pos_wide - ACT_START) : '0;

    // Parked on the last position so the first advance lands on zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg <= LAST;
        end else begin
            pos_reg <= pos_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe divider, HS/VS, active coordinates,
// display enable and line/frame pulses. Define VGA_FRAME_CNT_EN for frame_cnt.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter bit          HS_POL   = SYNC_ACT_LOW,
    parameter bit          VS_POL   = SYNC_ACT_LOW,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned FRAME_W  = 8
) (
    input  logic             clk_50M,
    input  logic             reset,
    vga_timing_gen_if.master vid
);

    localparam int unsigned     DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_reg;
    logic               strobe;
    logic               h_wrap, v_wrap;
    logic               h_sync, v_sync;
    logic               h_act, v_act;
    logic [COORD_W-1:0] h_coord, v_coord;

    logic               hs_reg, vs_reg;
    logic [COORD_W-1:0] col_reg, row_reg;
    logic               disp_en_reg, pix_en_reg;
    logic               line_start_reg, frame_start_reg;

    assign strobe = (div_reg == DIV_LAST);

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
        end else begin
            div_reg <= strobe ? '0 : div_reg + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .SYNC    (H_SYNC),
        .BP      (H_BP),
        .ACTIVE  (H_ACTIVE),
        .FP      (H_FP),
        .COORD_W (COORD_W)
    ) u_h_axis (
        .clk       (clk_50M),
        .rst_n     (reset),
        .adv       (strobe),
        .wrap      (h_wrap),
        .in_sync   (h_sync),
        .in_active (h_act),
        .coord     (h_coord)
    );

    vga_axis_counter #(
        .SYNC    (V_SYNC),
        .BP      (V_BP),
        .ACTIVE  (V_ACTIVE),
        .FP      (V_FP),
        .COORD_W (COORD_W)
    ) u_v_axis (
        .clk       (clk_50M),
        .rst_n     (reset),
        .adv       (strobe & h_wrap),
        .wrap      (v_wrap),
        .in_sync   (v_sync),
        .in_active (v_act),
        .coord     (v_coord)
    );

    // Position only moves on a strobe, so decoded outputs are refreshed only then;
    // this keeps reset values in place until the first pixel lands on (0,0).
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            hs_reg          <= ~HS_POL;
            vs_reg          <= ~VS_POL;
            col_reg         <= '0;
            row_reg         <= '0;
            disp_en_reg     <= 1'b0;
            pix_en_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            pix_en_reg      <= strobe;
            line_start_reg  <= strobe & h_wrap;
            frame_start_reg <= strobe & h_wrap & v_wrap;
            if (strobe) begin
                hs_reg      <= h_sync ? HS_POL : ~HS_POL;
                vs_reg      <= v_sync ? VS_POL : ~VS_POL;
                col_reg     <= h_coord;
                row_reg     <= v_coord;
                disp_en_reg <= h_act & v_act;
            end
        end
    end

    assign vid.HS          = hs_reg;
    assign vid.VS          = vs_reg;
    assign vid.col         = col_reg;
    assign vid.row         = row_reg;
    assign vid.disp_en     = disp_en_reg;
    assign vid.pix_en      = pix_en_reg;
    assign vid.line_start  = line_start_reg;
    assign vid.frame_start = frame_start_reg;

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt_reg;

    // Starts at all-ones so the first frame_start brings it to zero.
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            frame_cnt_reg <= '1;
        end else if (strobe & h_wrap & v_wrap) begin
            frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
        end
    end

    assign vid.frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked cycle by cycle against
// an arithmetic raster model through a scoreboard queue, plus aggregate counts.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [9:0] col;
        logic [9:0] row;
        logic       de;
        logic       pe;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } vid_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n = 0;
    int checks = 0;
    int errors = 0;
    bit agg_on = 1'b1;

    vid_t q_def[$];
    vid_t q_sml[$];
    vid_t q_med[$];

    int def_hs_low = 0, def_pe = 0, def_ls = 0;
    int sml_fs = 0, sml_ls = 0, sml_hs_hi = 0;
    int med_de = 0, med_last_col = -1, med_last_row = -1;
    int fc_seen = 0;
    int fc_log[5];

    vga_timing_gen_if #(.COORD_W(10), .FRAME_W(8)) vid_def ();
    vga_timing_gen_if #(.COORD_W(3),  .FRAME_W(2)) vid_sml ();
    vga_timing_gen_if #(.COORD_W(3),  .FRAME_W(3)) vid_med ();

    vga_timing_gen dut_def (
        .clk_50M (clk),
        .reset   (rst_n),
        .vid     (vid_def)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .COORD_W(3), .FRAME_W(2)
    ) dut_sml (
        .clk_50M (clk),
        .reset   (rst_n),
        .vid     (vid_sml)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_SYNC(3), .H_BP(2), .H_ACTIVE(5), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(4), .V_FP(2),
        .HS_POL(1'b0), .VS_POL(1'b1), .COORD_W(3), .FRAME_W(3)
    ) dut_med (
        .clk_50M (clk),
        .reset   (rst_n),
        .vid     (vid_med)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    // Expected outputs after the n-th enabled edge since reset release.
    function automatic vid_t model(input int cnt, input int cd,
                                   input int hsy, input int hbp, input int hac, input int hfp,
                                   input int vsy, input int vbp, input int vac, input int vfp,
                                   input bit hp, input bit vp, input int fw);
        vid_t r;
        int ht, vt, k, q, h, v;
        bit ha, va;
        ht = hsy + hbp + hac + hfp;
        vt = vsy + vbp + vac + vfp;
        k  = cnt / cd;
        r  = '0;
        if (k == 0) begin
            r.hs = ~hp;
            r.vs = ~vp;
            r.fc = 8'((1 << fw) - 1);
        end else begin
            q  = k - 1;
            h  = q % ht;
            v  = (q / ht) % vt;
            ha = (h >= hsy + hbp) && (h < hsy + hbp + hac);
            va = (v >= vsy + vbp) && (v < vsy + vbp + vac);
            r.hs  = (h < hsy) ? hp : ~hp;
            r.vs  = (v < vsy) ? vp : ~vp;
            r.col = ha ? 10'(h - hsy - hbp) : 10'd0;
            r.row = va ? 10'(v - vsy - vbp) : 10'd0;
            r.de  = ha && va;
            r.pe  = (cnt % cd) == 0;
            r.ls  = r.pe && (h == 0);
            r.fs  = r.ls && (v == 0);
            r.fc  = 8'((q / (ht * vt)) % (1 << fw));
        end
`ifndef VGA_FRAME_CNT_EN
        r.fc = '0;
`endif
        return r;
    endfunction

    function automatic vid_t pack(input logic hs, input logic vs, input logic [9:0] col,
                                  input logic [9:0] row, input logic de, input logic pe,
                                  input logic ls, input logic fs, input logic [7:0] fc);
        vid_t r;
        r.hs = hs; r.vs = vs; r.col = col; r.row = row;
        r.de = de; r.pe = pe; r.ls = ls; r.fs = fs; r.fc = fc;
        return r;
    endfunction

    task automatic push_expected();
        q_def.push_back(model(n, 2, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0, 8));
        q_sml.push_back(model(n, 1, 2, 1, 4, 1, 1, 1, 3, 1, 1'b1, 1'b0, 2));
        q_med.push_back(model(n, 3, 3, 2, 5, 2, 2, 1, 4, 2, 1'b0, 1'b1, 3));
    endtask

    task automatic compare_all();
        vid_t a_def, a_sml, a_med;
        logic [7:0] fc_def, fc_sml, fc_med;
        fc_def = '0; fc_sml = '0; fc_med = '0;
`ifdef VGA_FRAME_CNT_EN
        fc_def = 8'(vid_def.frame_cnt);
        fc_sml = 8'(vid_sml.frame_cnt);
        fc_med = 8'(vid_med.frame_cnt);
`endif
        a_def = pack(vid_def.HS, vid_def.VS, 10'(vid_def.col), 10'(vid_def.row), vid_def.disp_en,
                     vid_def.pix_en, vid_def.line_start, vid_def.frame_start, fc_def);
        a_sml = pack(vid_sml.HS, vid_sml.VS, 10'(vid_sml.col), 10'(vid_sml.row), vid_sml.disp_en,
                     vid_sml.pix_en, vid_sml.line_start, vid_sml.frame_start, fc_sml);
        a_med = pack(vid_med.HS, vid_med.VS, 10'(vid_med.col), 10'(vid_med.row), vid_med.disp_en,
                     vid_med.pix_en, vid_med.line_start, vid_med.frame_start, fc_med);
        check_eq("def_outs", 64'(a_def), 64'(q_def.pop_front()));
        check_eq("sml_outs", 64'(a_sml), 64'(q_sml.pop_front()));
        check_eq("med_outs", 64'(a_med), 64'(q_med.pop_front()));

        if (a_def.ls) $display("def line_start n=%0d HS=%0b VS=%0b", n, a_def.hs, a_def.vs);
        if (a_sml.fs) $display("sml frame_start n=%0d frame_cnt=%0d", n, a_sml.fc);
        if (a_med.fs) $display("med frame_start n=%0d frame_cnt=%0d", n, a_med.fc);

        if (a_sml.fs && fc_seen < 5) begin
            fc_log[fc_seen] = int'(a_sml.fc);
            fc_seen++;
        end

        if (agg_on) begin
            if (n >= 2 && n <= 1601) begin
                def_hs_low += (a_def.hs == 1'b0) ? 1 : 0;
                def_pe     += a_def.pe ? 1 : 0;
                def_ls     += a_def.ls ? 1 : 0;
            end
            if (n >= 1 && n <= 96) begin
                sml_fs    += a_sml.fs ? 1 : 0;
                sml_ls    += a_sml.ls ? 1 : 0;
                sml_hs_hi += a_sml.hs ? 1 : 0;
            end
            if (n >= 1 && n <= 324 && a_med.de) begin
                med_de++;
                med_last_col = int'(a_med.col);
                med_last_row = int'(a_med.row);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) n++;
        else n = 0;
        push_expected();
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        while (n < 1700) step();
        agg_on = 1'b0;
        check_eq("def_hs_low_clks", 64'(def_hs_low), 64'(192));
        check_eq("def_pix_per_line", 64'(def_pe), 64'(800));
        check_eq("def_line_starts", 64'(def_ls), 64'(1));
        check_eq("sml_frame_starts", 64'(sml_fs), 64'(2));
        check_eq("sml_line_starts", 64'(sml_ls), 64'(12));
        check_eq("sml_hs_high_clks", 64'(sml_hs_hi), 64'(24));
        check_eq("med_de_clks", 64'(med_de), 64'(60));
        check_eq("med_last_col", 64'(med_last_col), 64'(4));
        check_eq("med_last_row", 64'(med_last_row), 64'(3));
`ifdef VGA_FRAME_CNT_EN
        for (int i = 0; i < 5; i++) begin
            check_eq("sml_frame_cnt_seq", 64'(fc_log[i]), 64'(i % 4));
        end
`endif

        // Default instance now sits at h=300 of line 4; reset must act without a clock edge.
        while (n < 7002) step();
        rst_n = 1'b0;
        #1;
        n = 0;
        push_expected();
        compare_all();
        repeat (2) step();
        rst_n = 1'b1;
        while (n < 3300) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
